// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer: per-bit 2-flop synchronizer, tick-gated
// disagreement counter, and registered rise/fall/change pulses.
`timescale 1ns/1ps
module sw_debounce #(
  parameter int SW_WIDTH       = 4,
  parameter int CNT_WIDTH      = 14,
  parameter int DEBOUNCE_LIMIT = 10000,
  parameter int TICK_DIV       = 1
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic [SW_WIDTH-1:0] i_sw_raw,
  output logic [SW_WIDTH-1:0] o_sw,
  output logic [SW_WIDTH-1:0] o_sw_rise,
  output logic [SW_WIDTH-1:0] o_sw_fall,
  output logic                o_change
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DEBOUNCE_LIMIT - 1);

  logic [TICK_W-1:0]   tick_cnt_reg;
  logic [TICK_W-1:0]   tick_cnt_next;
  logic                tick;
  logic [SW_WIDTH-1:0] rise_next_vec;
  logic [SW_WIDTH-1:0] fall_next_vec;
  logic                change_reg;
  logic                change_next;

  // With TICK_DIV=1 the counter is stuck at 0 == TICK_LAST, so tick is constant 1.
  always_comb begin
    tick          = (tick_cnt_reg == TICK_LAST);
    tick_cnt_next = tick ? '0 : tick_cnt_reg + TICK_W'(1);
    change_next   = |(rise_next_vec | fall_next_vec);
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      tick_cnt_reg <= '0;
      change_reg   <= 1'b0;
    end else begin
      tick_cnt_reg <= tick_cnt_next;
      change_reg   <= change_next;
    end
  end

  assign o_change = change_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SW_WIDTH; gi++) begin : g_chan
      logic                 sync1_reg;
      logic                 sync2_reg;
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic [CNT_WIDTH-1:0] cnt_next;
      logic                 sw_reg;
      logic                 sw_next;
      logic                 rise_reg;
      logic                 rise_next;
      logic                 fall_reg;
      logic                 fall_next;

      // Any tick where the synchronized level agrees discards the partial count.
      always_comb begin
        cnt_next  = cnt_reg;
        sw_next   = sw_reg;
        rise_next = 1'b0;
        fall_next = 1'b0;
        if (tick) begin
          if (sync2_reg != sw_reg) begin
            if (cnt_reg >= CNT_LAST) begin
              sw_next   = sync2_reg;
              cnt_next  = '0;
              rise_next = sync2_reg;
              fall_next = ~sync2_reg;
            end else begin
              cnt_next = cnt_reg + CNT_WIDTH'(1);
            end
          end else begin
            cnt_next = '0;
          end
        end
      end

      always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          cnt_reg   <= '0;
          sw_reg    <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          sync1_reg <= i_sw_raw[gi];
          sync2_reg <= sync1_reg;
          cnt_reg   <= cnt_next;
          sw_reg    <= sw_next;
          rise_reg  <= rise_next;
          fall_reg  <= fall_next;
        end
      end

      assign rise_next_vec[gi] = rise_next;
      assign fall_next_vec[gi] = fall_next;
      assign o_sw[gi]          = sw_reg;
      assign o_sw_rise[gi]     = rise_reg;
      assign o_sw_fall[gi]     = fall_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: three instances cover the default timing,
// a divided sample tick, and the single-tick acceptance limit.
`timescale 1ns/1ps
module tb_sw_debounce;

  logic       clock;
  logic       i_reset;
  logic [3:0] raw_a, raw_b, raw_c;
  logic [3:0] sw_a, rise_a, fall_a;
  logic [3:0] sw_b, rise_b, fall_b;
  logic [3:0] sw_c, rise_c, fall_c;
  logic       chg_a, chg_b, chg_c;

  int checks = 0;
  int errors = 0;

  // A: TICK_DIV=1, LIMIT=4
  sw_debounce #(.SW_WIDTH(4), .CNT_WIDTH(4), .DEBOUNCE_LIMIT(4), .TICK_DIV(1)) dut_a (
    .clock(clock), .i_reset(i_reset), .i_sw_raw(raw_a),
    .o_sw(sw_a), .o_sw_rise(rise_a), .o_sw_fall(fall_a), .o_change(chg_a));

  // B: TICK_DIV=3, LIMIT=2
  sw_debounce #(.SW_WIDTH(4), .CNT_WIDTH(4), .DEBOUNCE_LIMIT(2), .TICK_DIV(3)) dut_b (
    .clock(clock), .i_reset(i_reset), .i_sw_raw(raw_b),
    .o_sw(sw_b), .o_sw_rise(rise_b), .o_sw_fall(fall_b), .o_change(chg_b));

  // C: TICK_DIV=1, LIMIT=1
  sw_debounce #(.SW_WIDTH(4), .CNT_WIDTH(4), .DEBOUNCE_LIMIT(1), .TICK_DIV(1)) dut_c (
    .clock(clock), .i_reset(i_reset), .i_sw_raw(raw_c),
    .o_sw(sw_c), .o_sw_rise(rise_c), .o_sw_fall(fall_c), .o_change(chg_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s observed=%b expected=%b ok", tag, obs, exp);
    end else begin
      errors++;
      $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
      $error("%s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] prev_pulse;
    logic [3:0] cur_pulse;
    i_reset = 1'b1;
    raw_a = 4'b0000;
    raw_b = 4'b0000;
    raw_c = 4'b0000;
    step();
    step();

    // reset state
    chk("reset_sw_a",   sw_a,   4'b0000);
    chk("reset_rise_a", rise_a, 4'b0000);
    chk("reset_fall_a", fall_a, 4'b0000);
    chk("reset_chg_a",  {3'b000, chg_a}, 4'b0000);
    i_reset = 1'b0;

    // divided tick: ticks land on edges 3,6,9 after release; raw changes after edge 1
    step();
    raw_b = 4'b0100;
    for (int n = 2; n <= 10; n++) begin
      step();
      chk($sformatf("b_sw_e%0d", n),   sw_b,   (n >= 9) ? 4'b0100 : 4'b0000);
      chk($sformatf("b_rise_e%0d", n), rise_b, (n == 9) ? 4'b0100 : 4'b0000);
      chk($sformatf("b_fall_e%0d", n), fall_b, 4'b0000);
      chk($sformatf("b_chg_e%0d", n),  {3'b000, chg_b}, (n == 9) ? 4'b0001 : 4'b0000);
    end

    // first acquisition: accept at edge 6
    raw_a = 4'b1001;
    for (int n = 1; n <= 7; n++) begin
      step();
      chk($sformatf("a_acq_sw_e%0d", n),   sw_a,   (n >= 6) ? 4'b1001 : 4'b0000);
      chk($sformatf("a_acq_rise_e%0d", n), rise_a, (n == 6) ? 4'b1001 : 4'b0000);
      chk($sformatf("a_acq_fall_e%0d", n), fall_a, 4'b0000);
      chk($sformatf("a_acq_chg_e%0d", n),  {3'b000, chg_a}, (n == 6) ? 4'b0001 : 4'b0000);
    end

    // two-cycle glitch on bit 3 is rejected
    raw_a = 4'b0001;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (n == 2) raw_a = 4'b1001;
      chk($sformatf("a_gl_sw_e%0d", n), sw_a, 4'b1001);
      chk($sformatf("a_gl_pulse_e%0d", n), rise_a | fall_a, 4'b0000);
      chk($sformatf("a_gl_chg_e%0d", n), {3'b000, chg_a}, 4'b0000);
    end

    // simultaneous rise on bit 1 and fall on bit 3
    raw_a = 4'b0011;
    for (int n = 1; n <= 7; n++) begin
      step();
      chk($sformatf("a_mix_sw_e%0d", n),   sw_a,   (n >= 6) ? 4'b0011 : 4'b1001);
      chk($sformatf("a_mix_rise_e%0d", n), rise_a, (n == 6) ? 4'b0010 : 4'b0000);
      chk($sformatf("a_mix_fall_e%0d", n), fall_a, (n == 6) ? 4'b1000 : 4'b0000);
      chk($sformatf("a_mix_chg_e%0d", n),  {3'b000, chg_a}, (n == 6) ? 4'b0001 : 4'b0000);
    end

    // reset mid-count, asserted between edges
    raw_a = 4'b0000;
    for (int n = 1; n <= 3; n++) begin
      step();
      chk($sformatf("a_pre_rst_sw_e%0d", n), sw_a, 4'b0011);
    end
    #1;
    i_reset = 1'b1;
    #1;
    chk("async_rst_sw_a",   sw_a,   4'b0000);
    chk("async_rst_pulses", rise_a | fall_a, 4'b0000);
    chk("async_rst_chg_a",  {3'b000, chg_a}, 4'b0000);
    chk("async_rst_sw_b",   sw_b,   4'b0000);
    raw_a = 4'b0001;
    step();
    step();
    chk("rst_hold_sw_a", sw_a, 4'b0000);
    i_reset = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      step();
      chk($sformatf("a_rel_sw_e%0d", n),   sw_a,   (n >= 6) ? 4'b0001 : 4'b0000);
      chk($sformatf("a_rel_rise_e%0d", n), rise_a, (n == 6) ? 4'b0001 : 4'b0000);
      chk($sformatf("a_rel_fall_e%0d", n), fall_a, 4'b0000);
      chk($sformatf("a_rel_chg_e%0d", n),  {3'b000, chg_a}, (n == 6) ? 4'b0001 : 4'b0000);
    end

    // LIMIT=1: raw toggles every 3 edges, each accepted 3 edges later
    raw_c = 4'b0001;
    prev_pulse = 4'b0000;
    for (int n = 1; n <= 12; n++) begin
      step();
      chk($sformatf("c_sw_e%0d", n), sw_c,
          ((n >= 3) && (((n / 3) % 2) == 1)) ? 4'b0001 : 4'b0000);
      chk($sformatf("c_rise_e%0d", n), rise_c, ((n % 6) == 3) ? 4'b0001 : 4'b0000);
      chk($sformatf("c_fall_e%0d", n), fall_c, ((n % 6) == 0) ? 4'b0001 : 4'b0000);
      chk($sformatf("c_chg_e%0d", n),  {3'b000, chg_c}, ((n % 3) == 0) ? 4'b0001 : 4'b0000);
      cur_pulse = rise_c | fall_c;
      chk($sformatf("c_adjacent_e%0d", n), prev_pulse & cur_pulse, 4'b0000);
      prev_pulse = cur_pulse;
      if (((n % 3) == 0) && (n < 12)) raw_c = raw_c ^ 4'b0001;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter SW_WIDTH, default 4: number of independent switch channels.
REQ-002 SHALL have parameter CNT_WIDTH, default 14: width of each per-channel debounce counter.
REQ-003 SHALL have parameter DEBOUNCE_LIMIT, default 10000: consecutive sample ticks of disagreement required to accept a new level; legal range 1..2^CNT_WIDTH-1.
REQ-004 SHALL have parameter TICK_DIV, default 1: clock cycles per sample tick; legal range >=1.
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port i_sw_raw  input  SW_WIDTH  raw asynchronous switch levels.
REQ-008 SHALL have port o_sw  output  SW_WIDTH  debounced switch levels; this is the i_sw source for the top-level counter/LED block.
REQ-009 SHALL have port o_sw_rise  output  SW_WIDTH  per-bit one-cycle pulse when o_sw bit goes 0->1.
REQ-010 SHALL have port o_sw_fall  output  SW_WIDTH  per-bit one-cycle pulse when o_sw bit goes 1->0.
REQ-011 SHALL have port o_change  output  1  one-cycle pulse, OR of all o_sw_rise and o_sw_fall bits.

Function
REQ-012 SHALL pass each i_sw_raw bit through a 2-flop synchronizer (sync1, sync2), reset value 0.
REQ-013 SHALL run a tick counter 0..TICK_DIV-1 wrapping to 0; tick asserted in the cycle counter = TICK_DIV-1; TICK_DIV=1 means tick every cycle.
REQ-014 SHALL, per bit, on a tick with sync2 != o_sw and cnt < DEBOUNCE_LIMIT-1: cnt <= cnt+1, o_sw held.
REQ-015 SHALL, per bit, on a tick with sync2 != o_sw and cnt = DEBOUNCE_LIMIT-1: o_sw <= sync2, cnt <= 0, matching rise/fall bit = 1 for that cycle only.
REQ-016 SHALL, per bit, on a tick with sync2 = o_sw: cnt <= 0 (glitch rejection; partial count discarded).
REQ-017 SHALL hold cnt and o_sw on non-tick cycles.
REQ-018 SHALL register o_sw_rise, o_sw_fall, o_change; all are 0 in every cycle without an accepted transition.
REQ-019 SHALL assert o_change in the same cycle as the pulses it summarizes.
REQ-020 SHALL treat channels independently; simultaneous acceptances on several bits SHALL pulse all those bits in the same cycle with a single-cycle o_change.
REQ-021 SHALL, with TICK_DIV=1, update o_sw at rising edge LIMIT+2 counted from the first edge sampling a new stable raw level (edge 1 -> sync1, edge 2 -> sync2, edges 3..LIMIT+2 -> count/accept).
REQ-022 SHALL never wrap cnt; maximum value is DEBOUNCE_LIMIT-1.
REQ-023 SHALL, with DEBOUNCE_LIMIT=1, accept a differing sync2 on its first tick.

Reset
REQ-024 SHALL, while i_reset=1, force sync1, sync2, cnt, tick counter, o_sw, o_sw_rise, o_sw_fall and o_change to 0 immediately, independent of clock.
REQ-025 SHALL, on reset asserted mid-count, discard partial counts; after release, debounce restarts from the synchronizer with o_sw=0.
REQ-026 SHALL resume operation on the first rising edge after i_reset deasserts; o_sw bits with raw=1 are re-acquired as rising transitions with pulses.

Verification (SW_WIDTH=4, TICK_DIV=1, DEBOUNCE_LIMIT=4 unless noted)
REQ-027 SHALL verify: reset, then i_sw_raw=4'b1001 held -> o_sw=4'b1001 at edge 6; o_sw_rise=4'b1001 and o_change=1 for exactly that cycle; o_sw_fall=0 throughout.
REQ-028 SHALL verify: from o_sw=4'b1001, bit 3 pulsed low for 2 cycles -> o_sw stays 4'b1001; no pulses.
REQ-029 SHALL verify: from o_sw=4'b1001, i_sw_raw=4'b0011 held -> at edge 6, o_sw=4'b0011, o_sw_rise=4'b0010, o_sw_fall=4'b1000, single o_change pulse.
REQ-030 SHALL verify: i_reset asserted mid-count (3 edges into a transition) -> all outputs 0 asynchronously; after release with raw=4'b0001, o_sw=4'b0001 at edge 6 after release with rise pulse.
REQ-031 SHALL verify: TICK_DIV=3, DEBOUNCE_LIMIT=2, raw 0->4'b0100 -> o_sw changes only on a tick edge, after exactly 2 ticks of disagreement after sync2 updates; cnt and o_sw hold between ticks.
REQ-032 SHALL verify: DEBOUNCE_LIMIT=1, raw toggles every 3 cycles -> each toggle accepted, alternating rise/fall pulses on bit 0, never two pulses in adjacent cycles.
